// File: rtl/data_mem.sv
// Byte-addressable data memory for the load/store stage: sized, lane-masked
// accesses over a valid/ready request port with a registered response.
module data_mem #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned INIT_MODE = 1,
    parameter int unsigned ADDR_W    = $clog2(DEPTH) + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault,
    output logic              init_busy
);

    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam int unsigned CNT_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] init_cnt, init_cnt_nxt;
    logic             init_we;
    logic [31:0]      init_word;

    logic [31:0]      mem [DEPTH];

    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             accept;
    logic             fault;
    logic             store_en;
    logic [31:0]      rd_word;
    logic [31:0]      rd_shift;
    logic [31:0]      load_data;
    logic [3:0]       be;
    logic [31:0]      wr_data;

    // State and sweep counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
        end
    end

    // Next state: sweep every word once, then serve requests
    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        init_we      = 1'b0;
        case (state)
            INIT: begin
                init_we      = 1'b1;
                init_cnt_nxt = init_cnt + CNT_W'(1);
                if (init_cnt == LAST_IDX) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                state_nxt = RUN;
            end
            default: state_nxt = INIT;
        endcase
    end

    assign init_word = (INIT_MODE == 1) ? (32'(init_cnt) + 32'd1) : 32'd0;

    // Request decode; aligned accesses always fit inside the addressed word
    always_comb begin
        idx      = req_addr[ADDR_W-1:2];
        lane     = req_addr[1:0];
        accept   = req_valid & req_ready;
        fault    = (req_size == 2'b11)
                 | ((req_size == 2'b01) & req_addr[0])
                 | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
        store_en = accept & req_we & ~fault;
        rd_word  = mem[idx];
        rd_shift = rd_word >> {lane, 3'b000};
        wr_data  = req_wdata << {lane, 3'b000};
        case (req_size)
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = 4'b0011 << lane;
            default: be = 4'b1111;
        endcase
        case (req_size)
            2'b00:   load_data = req_signed ? {{24{rd_shift[7]}}, rd_shift[7:0]}
                                            : {24'd0, rd_shift[7:0]};
            2'b01:   load_data = req_signed ? {{16{rd_shift[15]}}, rd_shift[15:0]}
                                            : {16'd0, rd_shift[15:0]};
            default: load_data = rd_word;
        endcase
    end

    // Storage: contents survive reset; the sweep rewrites them afterwards
    always_ff @(posedge clk) begin
        if (rst) begin
            if (init_we) begin
                mem[init_cnt] <= init_word;
            end else if (store_en) begin
                for (int k = 0; k < 4; k++) begin
                    if (be[k]) begin
                        mem[idx][8*k +: 8] <= wr_data[8*k +: 8];
                    end
                end
            end
        end
    end

    // Registered handshake and response
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_ready <= 1'b0;
            init_busy <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_fault <= 1'b0;
        end else begin
            req_ready <= (state_nxt == RUN);
            init_busy <= (state_nxt == INIT);
            rsp_valid <= accept;
            rsp_fault <= accept & fault;
            rsp_rdata <= (accept & ~fault & ~req_we) ? load_data : 32'd0;
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed scenarios followed by random
// traffic, compared against a byte-array reference model.
module tb_data_mem;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned NBYTES = DEPTH * 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_fault;
    logic              init_busy;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] rb [NBYTES];

    data_mem #(.DEPTH(DEPTH), .INIT_MODE(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault),
        .init_busy  (init_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes_of(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic model_fault(input logic [1:0] size, input int addr);
        return (size == 2'b11) || (size == 2'b01 && addr % 2 != 0)
            || (size == 2'b10 && addr % 4 != 0);
    endfunction

    task automatic model_init();
        for (int w = 0; w < int'(DEPTH); w++) begin
            logic [31:0] v;
            v = 32'(w + 1);
            for (int k = 0; k < 4; k++) rb[4*w + k] = 8'(v >> (8*k));
        end
    endtask

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn, input int addr);
        int          n;
        logic [31:0] v;
        logic [31:0] mask;
        n = nbytes_of(size);
        v = 32'd0;
        for (int k = 0; k < n; k++) v = v | (32'(rb[addr + k]) << (8*k));
        if (n < 4) begin
            mask = (32'd1 << (8*n)) - 32'd1;
            if (sgn && v[8*n - 1]) v = v | ~mask;
        end
        return v;
    endfunction

    task automatic model_store(input logic [1:0] size, input int addr, input logic [31:0] wdata);
        for (int k = 0; k < nbytes_of(size); k++) rb[addr + k] = 8'(wdata >> (8*k));
    endtask

    // Issue one request at the current time, check its response one edge later
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                          input string tag);
        logic        flt;
        logic [31:0] exp;
        flt = model_fault(size, int'(addr));
        exp = (flt || we) ? 32'd0 : model_load(size, sgn, int'(addr));
        if (we && !flt) model_store(size, int'(addr), wdata);
        check({tag, "/ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check({tag, "/valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "/fault"}, 32'(rsp_fault), 32'(flt));
        check({tag, "/rdata"}, rsp_rdata, exp);
    endtask

    task automatic idle(input string tag);
        req_valid = 1'b0;
        req_addr  = 6'($urandom);
        @(posedge clk);
        #1;
        check({tag, "/idle_valid"}, 32'(rsp_valid), 32'd0);
    endtask

    // Sweep after reset release: ready must rise on exactly the DEPTH-th edge
    task automatic wait_sweep(input string tag);
        for (int i = 1; i <= int'(DEPTH); i++) begin
            @(posedge clk);
            #1;
            check({tag, "/sweep_ready"}, 32'(req_ready), 32'(i == int'(DEPTH)));
            check({tag, "/sweep_busy"}, 32'(init_busy), 32'(i != int'(DEPTH)));
            check({tag, "/sweep_rsp"}, 32'(rsp_valid), 32'd0);
        end
        model_init();
    endtask

    initial begin
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        check("rst/rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst/rsp_rdata", rsp_rdata, 32'd0);
        check("rst/rsp_fault", 32'(rsp_fault), 32'd0);
        check("rst/init_busy", 32'(init_busy), 32'd1);
        check("rst/req_ready", 32'(req_ready), 32'd0);

        rst = 1'b1;
        wait_sweep("init");

        for (int w = 0; w < int'(DEPTH); w++) begin
            do_req(1'b0, 2'b10, 1'b0, 6'(4*w), 32'd0, "init_load");
            check("init_load/value", rsp_rdata, 32'(w + 1));
        end

        do_req(1'b1, 2'b10, 1'b0, 6'h10, 32'h8081_7F01, "st_word");
        do_req(1'b1, 2'b00, 1'b0, 6'h12, 32'h0000_00AA, "st_byte");
        do_req(1'b0, 2'b10, 1'b0, 6'h10, 32'd0, "ld_lane");
        check("ld_lane/const", rsp_rdata, 32'h80AA_7F01);

        do_req(1'b0, 2'b00, 1'b1, 6'h12, 32'd0, "ld_sb");
        check("ld_sb/const", rsp_rdata, 32'hFFFF_FFAA);
        do_req(1'b0, 2'b00, 1'b0, 6'h12, 32'd0, "ld_ub");
        check("ld_ub/const", rsp_rdata, 32'h0000_00AA);
        do_req(1'b0, 2'b01, 1'b1, 6'h12, 32'd0, "ld_sh_hi");
        check("ld_sh_hi/const", rsp_rdata, 32'hFFFF_80AA);
        do_req(1'b0, 2'b01, 1'b1, 6'h10, 32'd0, "ld_sh_lo");
        check("ld_sh_lo/const", rsp_rdata, 32'h0000_7F01);
        do_req(1'b0, 2'b01, 1'b0, 6'h12, 32'd0, "ld_uh_hi");
        do_req(1'b0, 2'b00, 1'b1, 6'h13, 32'd0, "ld_sb_top");
        idle("ext");

        do_req(1'b1, 2'b10, 1'b0, 6'h06, 32'hDEAD_BEEF, "flt_st_word");
        check("flt_st_word/flag", 32'(rsp_fault), 32'd1);
        do_req(1'b0, 2'b01, 1'b0, 6'h05, 32'd0, "flt_ld_half");
        check("flt_ld_half/flag", 32'(rsp_fault), 32'd1);
        do_req(1'b0, 2'b11, 1'b0, 6'h00, 32'd0, "flt_ld_size3");
        do_req(1'b1, 2'b11, 1'b0, 6'h10, 32'h1111_1111, "flt_st_size3");
        do_req(1'b1, 2'b01, 1'b0, 6'h07, 32'h0000_5555, "flt_st_half");
        do_req(1'b0, 2'b10, 1'b0, 6'h04, 32'd0, "flt_unchanged");
        check("flt_unchanged/const", rsp_rdata, 32'd2);
        do_req(1'b0, 2'b10, 1'b0, 6'h10, 32'd0, "flt_unchanged10");
        idle("flt");

        do_req(1'b1, 2'b10, 1'b0, 6'h08, 32'h1234_5678, "b2b_st");
        do_req(1'b0, 2'b10, 1'b0, 6'h08, 32'd0, "b2b_ld");
        check("b2b_ld/const", rsp_rdata, 32'h1234_5678);
        idle("b2b");

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle("rand");
            end else begin
                do_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                       6'($urandom), $urandom, "rand");
            end
        end

        do_req(1'b0, 2'b10, 1'b0, 6'h08, 32'd0, "mid_ld");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst/rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst/rsp_rdata", rsp_rdata, 32'd0);
        check("mid_rst/init_busy", 32'(init_busy), 32'd1);
        check("mid_rst/req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        check("mid_rst2/rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b1;
        wait_sweep("resweep");
        do_req(1'b0, 2'b10, 1'b0, 6'h08, 32'd0, "resweep_ld");
        check("resweep_ld/const", rsp_rdata, 32'd3);
        do_req(1'b0, 2'b10, 1'b0, 6'h3C, 32'd0, "resweep_last");
        check("resweep_last/const", rsp_rdata, 32'd16);
        idle("end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
